// File: rtl/mux_arb.sv
// Registered N-to-1 multiplexer with fixed-select and round-robin arbitration.
// One output register stage with a valid/ready handshake on both sides, at full throughput.
module mux_arb #(
    parameter int MUX_NUM_INPUTS   = 8,
    parameter int MUX_INPUTS_WIDTH = 32,
    parameter int MUX_NSEL         = $clog2(MUX_NUM_INPUTS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        mode_i,
    input  logic [MUX_NSEL-1:0]         sel_i,
    input  logic [MUX_INPUTS_WIDTH-1:0] in_data_i [0:MUX_NUM_INPUTS-1],
    input  logic [MUX_NUM_INPUTS-1:0]   in_valid_i,
    output logic [MUX_NUM_INPUTS-1:0]   in_ready_o,
    output logic [MUX_INPUTS_WIDTH-1:0] out_data_o,
    output logic [MUX_NSEL-1:0]         out_src_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    localparam logic [MUX_NSEL-1:0] LAST_IDX = MUX_NSEL'(MUX_NUM_INPUTS - 1);

    logic [MUX_INPUTS_WIDTH-1:0] data_p1;
    logic [MUX_NSEL-1:0]         src_p1;
    logic                        vld_p1;
    logic [MUX_NSEL-1:0]         last_ptr;

    logic                        fix_hit;
    logic                        lo_hit;
    logic                        hi_hit;
    logic [MUX_NSEL-1:0]         lo_idx;
    logic [MUX_NSEL-1:0]         hi_idx;
    logic                        rr_hit;
    logic [MUX_NSEL-1:0]         rr_idx;
    logic                        grant_hit;
    logic [MUX_NSEL-1:0]         grant_idx;
    logic [MUX_INPUTS_WIDTH-1:0] grant_data;
    logic                        load;
    logic                        xfer;
    logic [MUX_NUM_INPUTS-1:0]   ready;

    // An out-of-range sel_i matches no channel, so it never produces a grant.
    always_comb begin
        fix_hit = 1'b0;
        for (int i = 0; i < MUX_NUM_INPUTS; i++) begin
            if (sel_i == MUX_NSEL'(i) && in_valid_i[i]) begin
                fix_hit = 1'b1;
            end
        end
    end

    // Round-robin: lowest valid index above last_ptr, otherwise wrap to the lowest valid index.
    always_comb begin
        lo_hit = 1'b0;
        lo_idx = '0;
        hi_hit = 1'b0;
        hi_idx = '0;
        for (int i = MUX_NUM_INPUTS - 1; i >= 0; i--) begin
            if (in_valid_i[i]) begin
                lo_hit = 1'b1;
                lo_idx = MUX_NSEL'(i);
                if (MUX_NSEL'(i) > last_ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = MUX_NSEL'(i);
                end
            end
        end
    end

    assign rr_hit    = lo_hit;
    assign rr_idx    = hi_hit ? hi_idx : lo_idx;
    assign grant_hit = mode_i ? rr_hit : fix_hit;
    assign grant_idx = mode_i ? rr_idx : sel_i;

    assign load = !vld_p1 || out_ready_i;
    assign xfer = grant_hit && load && !clr_i && !rst_i;

    always_comb begin
        ready      = '0;
        grant_data = '0;
        for (int i = 0; i < MUX_NUM_INPUTS; i++) begin
            if (grant_idx == MUX_NSEL'(i)) begin
                ready[i]   = xfer;
                grant_data = in_data_i[i];
            end
        end
    end

    assign in_ready_o = ready;

    // Stage p1: output register; flush takes priority over a load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            src_p1   <= '0;
            last_ptr <= LAST_IDX;
        end else if (clr_i) begin
            vld_p1   <= 1'b0;
            last_ptr <= LAST_IDX;
        end else if (load) begin
            vld_p1 <= grant_hit;
            if (grant_hit) begin
                data_p1  <= grant_data;
                src_p1   <= grant_idx;
                last_ptr <= grant_idx;
            end
        end
    end

    assign out_data_o  = data_p1;
    assign out_src_o   = src_p1;
    assign out_valid_o = vld_p1;

endmodule

// File: tb/tb_mux_arb.sv
// Randomized and directed bench for mux_arb against a behavioural arbitration model.
// The select port is widened to 4 bits so that out-of-range channel indices can be driven.
module tb_mux_arb;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          mode;
    logic [NS-1:0] sel;
    logic [W-1:0]  in_data [0:N-1];
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [NS-1:0] out_src;
    logic          out_valid;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;

    mux_arb #(
        .MUX_NUM_INPUTS  (N),
        .MUX_INPUTS_WIDTH(W),
        .MUX_NSEL        (NS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .mode_i     (mode),
        .sel_i      (sel),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_src_o  (out_src),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit vbit(input int c);
        return ((in_valid >> c) & 8'd1) != 8'd0;
    endfunction

    // Channel that would be granted this cycle, or -1.
    function automatic int model_grant();
        int s;
        int c;
        if (mode == 1'b0) begin
            s = int'(sel);
            if (s < N && vbit(s)) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (vbit(c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"}, 64'(out_valid), 64'(m_valid));
        chk({tag, "_data"}, 64'(out_data), 64'(m_data));
        chk({tag, "_src"}, 64'(out_src), 64'(m_src));
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step(input string tag);
        int g;
        bit ld;
        bit xf;
        #1;
        g  = model_grant();
        ld = !m_valid || out_ready;
        xf = (g >= 0) && ld && !clr && !rst;
        chk({tag, "_rdy"}, 64'(in_ready), xf ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        if (clr) begin
            m_valid = 1'b0;
            m_ptr   = N - 1;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g];
                m_src   = g;
                m_ptr   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int rr_exp [6] = '{0, 2, 5, 7, 0, 2};

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) in_data[k] = W'(k);
        model_reset();
        #3;
        check_outputs("por");
        chk("por_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed select of channel 3 with every channel valid
        mode = 1'b0; sel = 4'd3; in_valid = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("fix3_rdy_const", 64'(in_ready), 64'h08);
            step("fix3");
            chk("fix3_src_const", 64'(out_src), 64'd3);
        end

        // Round-robin from reset over a sparse valid pattern
        do_reset();
        mode = 1'b1; in_valid = 8'b1010_0101; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step("rr");
            chk("rr_seq", 64'(out_src), 64'(rr_exp[c]));
            chk("rr_vld", 64'(out_valid), 64'd1);
        end

        // Backpressure for four cycles, then release
        for (int k = 0; k < N; k++) in_data[k] = 32'hA000_0000 + W'(k);
        in_valid = 8'hFF;
        step("bp_load");
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) step("bp_hold");
        out_ready = 1'b1;
        step("bp_release");
        chk("bp_nobubble", 64'(out_valid), 64'd1);

        // Out-of-range fixed select drains the register and grants nothing
        mode = 1'b0; sel = 4'd9;
        for (int c = 0; c < 3; c++) step("sel9");
        chk("sel9_empty", 64'(out_valid), 64'd0);

        // Flush while holding data with every input valid
        mode = 1'b1; sel = 4'd0; in_valid = 8'hFF;
        step("pre_clr");
        step("pre_clr");
        out_ready = 1'b0;
        clr = 1'b1;
        step("clr");
        chk("clr_vld", 64'(out_valid), 64'd0);
        clr = 1'b0;
        out_ready = 1'b1;
        step("post_clr");
        chk("post_clr_src", 64'(out_src), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = NS'($urandom_range(0, 15));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < N; k++) in_data[k] = $urandom;
            step("rand");
        end
        clr = 1'b0;

        // Asynchronous reset between edges while holding data
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
        for (int k = 0; k < N; k++) in_data[k] = 32'hC0DE_0000 + W'(k);
        step("pre_arst");
        step("pre_arst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        chk("arst_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step("post_arst");
        chk("post_arst_src", 64'(out_src), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter MUX_NUM_INPUTS, default 8, number of input channels (2 or more).
REQ-002 Parameter MUX_INPUTS_WIDTH, default 32, data width per channel.
REQ-003 Parameter MUX_NSEL, default $clog2(MUX_NUM_INPUTS), select/index width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 clr_i  input  1  synchronous flush of output stage and arbitration pointer.
REQ-007 mode_i  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-008 sel_i  input  MUX_NSEL  channel index used in fixed mode.
REQ-009 in_data_i  input  MUX_INPUTS_WIDTH x MUX_NUM_INPUTS (unpacked [0:N-1])  per-channel data.
REQ-010 in_valid_i  input  MUX_NUM_INPUTS  per-channel valid.
REQ-011 in_ready_o  output  MUX_NUM_INPUTS  per-channel ready; one-hot or zero.
REQ-012 out_data_o  output  MUX_INPUTS_WIDTH  registered selected data.
REQ-013 out_src_o  output  MUX_NSEL  index of the channel that supplied out_data_o.
REQ-014 out_valid_o  output  1  output register holds data.
REQ-015 out_ready_i  input  1  downstream accepts data.

Function
REQ-016 The block SHALL contain a single output register: data, src, valid.
REQ-017 The load enable SHALL be load = !out_valid_o || out_ready_i, giving full throughput of 1 transfer per cycle.
REQ-018 In fixed mode, the candidate SHALL be sel_i. The grant SHALL be valid only if sel_i < MUX_NUM_INPUTS and in_valid_i[sel_i] = 1.
REQ-019 If sel_i >= MUX_NUM_INPUTS, the block SHALL make no grant and SHALL drive all in_ready_o to 0.
REQ-020 In round-robin mode, the candidate SHALL be the first asserted in_valid_i at or after index (last_ptr+1) mod MUX_NUM_INPUTS, searching upward and wrapping.
REQ-021 in_ready_o[g] SHALL be 1 only when g is granted, load = 1 and clr_i = 0. All other bits SHALL be 0. in_ready_o is combinational.
REQ-022 On a transfer (in_valid_i[g] && in_ready_o[g]), the block SHALL load out_data_o <= in_data_i[g], out_src_o <= g and out_valid_o <= 1 at the next edge.
REQ-023 When load = 1 and there is no grant, out_valid_o SHALL become 0 at the next edge. out_data_o and out_src_o SHALL hold their values.
REQ-024 last_ptr SHALL update to g only on a transfer, in both modes. Fixed-mode transfers therefore also move the round-robin start point.
REQ-025 Latency SHALL be 1 cycle from the input handshake to out_valid_o.
REQ-026 When out_valid_o = 1 and out_ready_i = 0, the output register SHALL hold stable and all in_ready_o SHALL be 0.
REQ-027 A simultaneous output drain and input transfer in the same cycle SHALL replace the register contents with no bubble.
REQ-028 A mode_i or sel_i change SHALL take effect in the same cycle's grant. It SHALL NOT affect data already registered.
REQ-029 When clr_i = 1, the next edge SHALL set out_valid_o to 0 and last_ptr to MUX_NUM_INPUTS-1. No input SHALL be accepted in that cycle. clr_i has priority over load.

Reset
REQ-030 Asserting rst_i SHALL immediately set out_valid_o = 0, out_data_o = 0, out_src_o = 0 and last_ptr = MUX_NUM_INPUTS-1, so the first round-robin search starts at index 0.
REQ-031 A reset asserted mid-transfer SHALL drop the held data. After release, the first grant SHALL follow REQ-018 or REQ-020 with last_ptr at its reset value.
REQ-032 While rst_i = 1, in_ready_o SHALL be 0.

Verification
REQ-033 Fixed mode, sel_i = 3, in_valid_i = 8'hFF, in_data_i[k] = k, out_ready_i = 1 -> in_ready_o = 8'h08 each cycle; out_data_o = 3, out_src_o = 3 from cycle 1 onward.
REQ-034 Round-robin, in_valid_i = 8'b1010_0101, out_ready_i = 1 from reset -> out_src_o sequence 0, 2, 5, 7, 0, ... with out_valid_o continuously 1.
REQ-035 Backpressure: out_ready_i = 0 for 4 cycles after a valid load -> out_data_o and out_src_o stable and in_ready_o = 0 throughout; on release, the next channel transfers in the same cycle with no bubble.
REQ-036 Fixed mode, sel_i = 9 with MUX_NUM_INPUTS = 8 -> in_ready_o = 0 and out_valid_o falls to 0 after draining.
REQ-037 clr_i pulse while out_valid_o = 1 and all inputs valid -> out_valid_o = 0 next cycle, no input accepted; the next round-robin grant is channel 0.
REQ-038 Asynchronous rst_i asserted between edges while holding data -> outputs go to zero immediately, without waiting for a clock edge.
